// File: rtl/rcc_ahb_slave_if_if.sv
// AHB-Lite address-phase and response signals between the interconnect
// and the reset/clock-control slave front-end.
interface rcc_ahb_slave_if_if #(
   parameter int ADDR_W = 12
);
   logic              HSEL;
   logic [ADDR_W-1:0] HADDR;
   logic [1:0]        HTRANS;
   logic              HWRITE;
   logic [2:0]        HSIZE;
   logic              HREADY;
   logic              HREADYOUT;
   logic              HRESP;

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY,
      output HREADYOUT, HRESP
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY,
      input  HREADYOUT, HRESP
   );
endinterface

// File: rtl/rcc_ahb_slave_if.sv
// AHB-Lite slave front-end for the reset/clock-control register block:
// qualifies address phases, drives data-phase strobes and inserts settling stalls.
module rcc_ahb_slave_if #(
   parameter int ADDR_W      = 12,
   parameter int WAIT_STATES = 4,
   parameter int CNT_W       = 4
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   rcc_ahb_slave_if_if.slave   ahb,
   output logic                HSEL_REG,
   output logic                HWRITE_REG,
   output logic [2:0]          HSIZE_REG,
   output logic                RD_SEL,
   output logic                BUSY
);

   typedef enum logic [2:0] {
      IDLE,
      WR_WAIT,
      RD_WAIT,
      ERR1,
      ERR2
   } state_t;

   localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             ready_int;
   logic             accept;
   logic             legal;
   logic             wr_go;
   logic             rd_go;

   // HREADYOUT is high exactly in cycles that may take a new address phase
   always_comb begin
      ready_int = 1'b1;
      case (state)
         IDLE:    ready_int = 1'b1;
         WR_WAIT: ready_int = (cnt == '0);
         RD_WAIT: ready_int = 1'b0;
         ERR1:    ready_int = 1'b0;
         ERR2:    ready_int = 1'b1;
         default: ready_int = 1'b1;
      endcase
   end

   // Only word 0 is mapped; sub-word access is limited to byte lane 0
   always_comb begin
      accept = ready_int & ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
      legal  = (ahb.HADDR[ADDR_W-1:2] == '0) &&
               (ahb.HSIZE <= 3'd2) &&
               ((ahb.HSIZE == 3'd2) || (ahb.HADDR[1:0] == 2'b00));
      wr_go  = accept & legal & ahb.HWRITE;
      rd_go  = accept & legal & ~ahb.HWRITE;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: state_nxt = IDLE;
         WR_WAIT: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else begin
               state_nxt = IDLE;
            end
         end
         RD_WAIT: state_nxt = IDLE;
         ERR1:    state_nxt = ERR2;
         ERR2:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (accept) begin
         cnt_nxt = '0;
         if (!legal) begin
            state_nxt = ERR1;
         end else if (ahb.HWRITE) begin
            if (WAIT_CNT == '0) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = WR_WAIT;
               cnt_nxt   = WAIT_CNT;
            end
         end else begin
            state_nxt = RD_WAIT;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Strobes last one cycle: the first data cycle of a qualified transfer
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         HSEL_REG   <= 1'b0;
         HWRITE_REG <= 1'b0;
         HSIZE_REG  <= 3'd0;
         RD_SEL     <= 1'b0;
      end else begin
         HSEL_REG   <= wr_go;
         HWRITE_REG <= wr_go;
         HSIZE_REG  <= wr_go ? ahb.HSIZE : 3'd0;
         RD_SEL     <= rd_go;
      end
   end

   assign ahb.HREADYOUT = ready_int;
   assign ahb.HRESP     = (state == ERR1) || (state == ERR2);
   assign BUSY          = (state != IDLE);

endmodule

// File: doc/rcc_ahb_slave_if.md
Name: rcc_ahb_slave_if

Overview:
AHB-Lite slave front-end for the reset/clock-control register block. It decodes and qualifies address phases, then drives the register block's data-phase strobes (HSEL_REG/HWRITE_REG/HSIZE_REG for writes, RD_SEL for reads). It generates HREADYOUT/HRESP toward the bus, including a programmable settling stall after divider writes so dependent clocks stabilise before the next access. It sits between the AHB interconnect and the clock/reset controller, in the HCLK domain.

Parameters:
ADDR_W, 12, width of the HADDR slice decoded by this slave
WAIT_STATES, 4, HREADYOUT-low cycles inserted in a write data phase (0..15)
CNT_W, 4, width of the wait-state counter; must hold WAIT_STATES

Ports:
HCLK  in  1  AHB clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select (address phase)
HADDR  in  ADDR_W  address (address phase)
HTRANS  in  2  transfer type; bit1=1 means NONSEQ/SEQ
HWRITE  in  1  write when 1 (address phase)
HSIZE  in  3  transfer size (address phase)
HREADY  in  1  bus ready (previous data phase completing)
HREADYOUT  out  1  slave ready
HRESP  out  1  1 = ERROR
HSEL_REG  out  1  write strobe to register block (data phase)
HWRITE_REG  out  1  write qualifier to register block
HSIZE_REG  out  3  registered HSIZE for the write
RD_SEL  out  1  read strobe to register block; its read data is valid one HCLK later
BUSY  out  1  1 while in any non-IDLE state

Behaviour:
- Reset is HRESETn, asynchronous, active-low; clock is HCLK, rising edge.
- Reset values: HREADYOUT=1, HRESP=0, HSEL_REG=0, HWRITE_REG=0, HSIZE_REG=0, RD_SEL=0, BUSY=0, state=IDLE, counter=0.
- Accept condition (evaluated only when state=IDLE, or in the final cycle of a data phase with HREADYOUT=1): HSEL & HREADY & HTRANS[1].
- Legal access requires all of the following:
  - HADDR[ADDR_W-1:2]==0;
  - HSIZE<=2;
  - HSIZE=1 requires HADDR[1:0]=0; HSIZE=0 requires HADDR[1:0]=0. Only lane 0 is writable/readable for sub-word access.
- Any other accepted transfer is illegal.
- IDLE/BUSY transfers, or HSEL=0: no strobes; OKAY response with zero wait.
- States: IDLE, WR_WAIT, RD_WAIT, ERR1, ERR2.
- Legal write:
  - Next cycle (data cycle 1): HSEL_REG=1, HWRITE_REG=1, HSIZE_REG=captured HSIZE, for exactly one cycle.
  - WAIT_STATES=0: HREADYOUT=1 in data cycle 1; state stays IDLE.
  - WAIT_STATES>0: go to WR_WAIT with counter=WAIT_STATES. HREADYOUT=0 while counter>0; counter decrements each cycle; HREADYOUT=1 on the cycle counter reaches 0, then return to IDLE.
  - Total write data phase = WAIT_STATES+1 cycles.
- Legal read:
  - Data cycle 1: RD_SEL=1, HREADYOUT=0, state=RD_WAIT.
  - Data cycle 2: RD_SEL=0, HREADYOUT=1, register read data is valid on the bus; return to IDLE.
- Illegal transfer:
  - ERR1: HRESP=1, HREADYOUT=0.
  - ERR2: HRESP=1, HREADYOUT=1; return to IDLE.
  - No strobes are asserted.
- Pipelining: an address phase presented in the final data cycle (HREADYOUT=1) is accepted, giving back-to-back transfers with no idle cycle. Address-phase inputs are ignored while HREADYOUT=0.
- BUSY=1 in WR_WAIT, RD_WAIT, ERR1, ERR2.
- Reset mid-operation: immediate return to reset values. A pending write stall or error is abandoned; no strobe is emitted after reset release until a new accepted transfer.
- HSEL_REG and RD_SEL are never asserted in the same cycle.

Test Plan:
- Word write, HADDR=0x000, HSIZE=2, WAIT_STATES=4 -> HSEL_REG/HWRITE_REG high 1 cycle with HSIZE_REG=2; HREADYOUT low 4 cycles then high; HRESP=0.
- Word read at 0x000 -> RD_SEL high in data cycle 1 with HREADYOUT=0; HREADYOUT=1 in cycle 2 with register data (0x00020202 after reset) on the bus.
- Write to HADDR=0x004, and halfword at HADDR=0x002 -> ERR1 (HRESP=1, HREADYOUT=0) then ERR2 (HRESP=1, HREADYOUT=1); no HSEL_REG pulse.
- Back-to-back write then read, WAIT_STATES=0 -> write strobe in cycle N, RD_SEL in cycle N+1, read completes in cycle N+2; no bubbles.
- HTRANS=IDLE with HSEL=1, and HSEL=0 with HTRANS=NONSEQ -> HREADYOUT=1, HRESP=0, no strobes.
- HRESETn asserted in the 2nd WR_WAIT cycle -> outputs at reset values immediately; after release, HREADYOUT=1 and no stray strobes.
